// File: rtl/reset_sequencer.sv
// Staged reset sequencer: merges enabled reset requests and sequences peripheral and CPU reset release.
// Latency: an enabled request sampled on one edge shows up on both resets at that edge; the periph
// release follows HOLD_CYCLES edges after the last request, and the CPU release follows on ready or timeout.
// Ports: clk_i/rst_i clock and async active-high POR; req_i/req_en_i requests and their enables;
//   periph_ready_i peripheral init done; cpu_reset_o/periph_reset_o staged resets; busy_o sequence active;
//   por_o/cause_o/timeout_o cause of the last reset; reset_count_o saturating count of triggered resets.
module reset_sequencer #(
  parameter int NUM_REQ        = 4,
  parameter int HOLD_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [NUM_REQ-1:0] req_en_i,
  input  logic               periph_ready_i,
  output logic               cpu_reset_o,
  output logic               periph_reset_o,
  output logic               busy_o,
  output logic               por_o,
  output logic [NUM_REQ-1:0] cause_o,
  output logic               timeout_o,
  output logic [7:0]         reset_count_o
);

  localparam int MAXC = (HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES : TIMEOUT_CYCLES;
  // Keep at least one counter bit so that a maximum of 1 still elaborates.
  localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] HOLD_LAST    = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    HOLD       = 2'd1,
    WAIT_READY = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               cpu_q, cpu_d;
  logic               per_q, per_d;
  logic               busy_q, busy_d;
  logic               por_q, por_d;
  logic [NUM_REQ-1:0] cause_q, cause_d;
  logic               to_q, to_d;
  logic [7:0]         count_q, count_d;

  logic [NUM_REQ-1:0] masked;
  logic               act;

  assign masked = req_i & req_en_i;
  assign act    = |masked;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cpu_d   = cpu_q;
    per_d   = per_q;
    por_d   = por_q;
    cause_d = cause_q;
    to_d    = to_q;
    count_d = count_q;

    case (state_q)
      IDLE: begin
        cpu_d = 1'b0;
        per_d = 1'b0;
        if (act) begin
          // A fresh reset: the cause record restarts and the counter advances once.
          state_d = HOLD;
          cnt_d   = '0;
          cpu_d   = 1'b1;
          per_d   = 1'b1;
          cause_d = masked;
          por_d   = 1'b0;
          to_d    = 1'b0;
          count_d = (count_q != 8'hFF) ? count_q + 8'd1 : count_q;
        end
      end

      HOLD: begin
        cpu_d = 1'b1;
        per_d = 1'b1;
        if (act) begin
          // A request during the hold extends the same reset.
          cnt_d   = '0;
          cause_d = cause_q | masked;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = WAIT_READY;
          per_d   = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      WAIT_READY: begin
        cpu_d = 1'b1;
        per_d = 1'b0;
        if (act) begin
          // The request wins over ready, so the CPU never escapes a pending reset.
          state_d = HOLD;
          per_d   = 1'b1;
          cnt_d   = '0;
          cause_d = cause_q | masked;
        end else if (periph_ready_i) begin
          state_d = IDLE;
          cpu_d   = 1'b0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = IDLE;
          cpu_d   = 1'b0;
          to_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        // An illegal encoding is treated as a reset in progress.
        state_d = HOLD;
        cnt_d   = '0;
        cpu_d   = 1'b1;
        per_d   = 1'b1;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      cpu_q   <= 1'b1;
      per_q   <= 1'b1;
      busy_q  <= 1'b1;
      por_q   <= 1'b1;
      cause_q <= '0;
      to_q    <= 1'b0;
      count_q <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cpu_q   <= cpu_d;
      per_q   <= per_d;
      busy_q  <= busy_d;
      por_q   <= por_d;
      cause_q <= cause_d;
      to_q    <= to_d;
      count_q <= count_d;
    end
  end

  assign cpu_reset_o    = cpu_q;
  assign periph_reset_o = per_q;
  assign busy_o         = busy_q;
  assign por_o          = por_q;
  assign cause_o        = cause_q;
  assign timeout_o      = to_q;
  assign reset_count_o  = count_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Testbench for reset_sequencer: directed scenarios followed by random requests, ready and POR pulses.
// The reference model tracks how many hold and wait edges remain; every output is checked after each edge.
module tb_reset_sequencer;
  localparam int N = 4;
  localparam int H = 16;
  localparam int T = 256;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [N-1:0] req_i;
  logic [N-1:0] req_en_i;
  logic         periph_ready_i;
  logic         cpu_reset_o;
  logic         periph_reset_o;
  logic         busy_o;
  logic         por_o;
  logic [N-1:0] cause_o;
  logic         timeout_o;
  logic [7:0]   reset_count_o;

  reset_sequencer #(.NUM_REQ(N), .HOLD_CYCLES(H), .TIMEOUT_CYCLES(T)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .req_i          (req_i),
    .req_en_i       (req_en_i),
    .periph_ready_i (periph_ready_i),
    .cpu_reset_o    (cpu_reset_o),
    .periph_reset_o (periph_reset_o),
    .busy_o         (busy_o),
    .por_o          (por_o),
    .cause_o        (cause_o),
    .timeout_o      (timeout_o),
    .reset_count_o  (reset_count_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: the sequence is in progress exactly while the CPU is held.
  bit           m_cpu, m_per, m_por, m_to;
  logic [N-1:0] m_cause;
  int           m_count;
  int           hold_left;  // edges still to go before peripheral release
  int           wait_left;  // edges still to go before CPU timeout release

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cpu = 1; m_per = 1; m_por = 1; m_to = 0;
    m_cause = '0; m_count = 0; hold_left = H; wait_left = T;
  endtask

  task automatic model_step(input logic [N-1:0] m, input logic rdy);
    if (!m_cpu) begin
      if (m != 0) begin
        m_cpu = 1; m_per = 1; m_cause = m; m_por = 0; m_to = 0;
        if (m_count < 255) m_count++;
        hold_left = H;
      end
    end else if (m_per) begin
      if (m != 0) begin
        hold_left = H;
        m_cause = m_cause | m;
      end else begin
        hold_left--;
        if (hold_left == 0) begin
          m_per = 0;
          wait_left = T;
        end
      end
    end else begin
      if (m != 0) begin
        m_per = 1; hold_left = H; m_cause = m_cause | m;
      end else if (rdy) begin
        m_cpu = 0;
      end else begin
        wait_left--;
        if (wait_left == 0) begin
          m_cpu = 0;
          m_to = 1;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    check_val({tag, ".cpu"},    32'(cpu_reset_o),    32'(m_cpu));
    check_val({tag, ".periph"}, 32'(periph_reset_o), 32'(m_per));
    check_val({tag, ".busy"},   32'(busy_o),         32'(m_cpu));
    check_val({tag, ".por"},    32'(por_o),          32'(m_por));
    check_val({tag, ".cause"},  32'(cause_o),        32'(m_cause));
    check_val({tag, ".tmo"},    32'(timeout_o),      32'(m_to));
    check_val({tag, ".count"},  32'(reset_count_o),  32'(m_count));
  endtask

  task automatic tick(input string tag);
    @(posedge clk_i);
    if (rst_i) model_reset();
    else model_step(req_i & req_en_i, periph_ready_i);
    #1;
    check_all(tag);
  endtask

  task automatic ticks(input string tag, input int n);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  // Waits for the sequencer to return to IDLE within a fixed budget.
  task automatic drain(input string tag);
    req_i = '0;
    periph_ready_i = 1'b1;
    ticks(tag, H + 2);
  endtask

  initial begin
    int base;
    // 1. Power-up
    rst_i = 1'b1; req_i = '0; req_en_i = 4'hF; periph_ready_i = 1'b1;
    #2;
    model_reset();
    check_all("por_async");
    ticks("por_hold", 3);
    #2 rst_i = 1'b0;
    ticks("t1", H - 1);
    check_val("t1_periph_before16", 32'(periph_reset_o), 32'd1);
    tick("t1");
    check_val("t1_periph_at16", 32'(periph_reset_o), 32'd0);
    check_val("t1_cpu_at16", 32'(cpu_reset_o), 32'd1);
    tick("t1");
    check_val("t1_cpu_at17", 32'(cpu_reset_o), 32'd0);
    check_val("t1_por", 32'(por_o), 32'd1);

    // 2. Single enabled request
    req_i = 4'b0010;
    tick("t2");
    check_val("t2_periph_on", 32'(periph_reset_o), 32'd1);
    check_val("t2_cause", 32'(cause_o), 32'h2);
    check_val("t2_count", 32'(reset_count_o), 32'd1);
    req_i = '0;
    ticks("t2", H - 1);
    check_val("t2_periph_hold", 32'(periph_reset_o), 32'd1);
    tick("t2");
    check_val("t2_periph_off", 32'(periph_reset_o), 32'd0);
    tick("t2");

    // 3. Masked request is ignored
    req_en_i = 4'b1101; req_i = 4'b0010;
    ticks("t3", 5);
    check_val("t3_busy", 32'(busy_o), 32'd0);
    check_val("t3_count", 32'(reset_count_o), 32'd1);
    req_i = '0; req_en_i = 4'hF;

    // 4. Second request restarts the hold
    req_i = 4'b0001;
    tick("t4");
    req_i = '0;
    ticks("t4", 10);
    req_i = 4'b1000;
    tick("t4");
    req_i = '0;
    ticks("t4", H - 1);
    check_val("t4_periph_hold", 32'(periph_reset_o), 32'd1);
    tick("t4");
    check_val("t4_periph_off", 32'(periph_reset_o), 32'd0);
    check_val("t4_cause", 32'(cause_o), 32'h9);
    check_val("t4_count", 32'(reset_count_o), 32'd2);
    tick("t4");

    // 5. Timeout release
    periph_ready_i = 1'b0;
    req_i = 4'b0100;
    tick("t5");
    req_i = '0;
    ticks("t5", H);
    ticks("t5", T - 1);
    check_val("t5_cpu_before_to", 32'(cpu_reset_o), 32'd1);
    tick("t5");
    check_val("t5_cpu_to", 32'(cpu_reset_o), 32'd0);
    check_val("t5_timeout", 32'(timeout_o), 32'd1);
    req_i = 4'b0100;
    tick("t5");
    check_val("t5_timeout_clr", 32'(timeout_o), 32'd0);
    req_i = '0;
    ticks("t5", H);

    // 6. Request beats ready, then async POR mid-hold
    req_i = 4'b0001; periph_ready_i = 1'b1;
    tick("t6");
    check_val("t6_cpu_hold", 32'(cpu_reset_o), 32'd1);
    check_val("t6_periph_back", 32'(periph_reset_o), 32'd1);
    req_i = '0;
    ticks("t6", 5);
    #2 rst_i = 1'b1;
    #1;
    model_reset();
    check_all("t6_async");
    check_val("t6_count_zero", 32'(reset_count_o), 32'd0);
    tick("t6");
    #2 rst_i = 1'b0;
    drain("t6_drain");

    // Random phase
    for (int i = 0; i < 4000; i++) begin
      req_en_i = 4'($urandom);
      req_i = ($urandom_range(0, 19) == 0) ? 4'($urandom) : 4'b0000;
      periph_ready_i = ($urandom_range(0, 99) < ((i / 500) % 2 == 1 ? 1 : 40));
      if ($urandom_range(0, 999) == 0) rst_i = 1'b1;
      tick("rnd");
      if (rst_i) begin
        #2 rst_i = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
